// File: rtl/ldl_fifo_rd_stream_if.sv
// ldl_fifo_rd_stream_if: registered valid/ready stream produced by the FIFO
// read-side adapter. The adapter drives the master side. The consumer
// (or testbench) drives the slave side.
interface ldl_fifo_rd_stream_if #(
    parameter int DW = 8
);
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/ldl_fifo_rd_stream.sv
// ldl_fifo_rd_stream: turns the synchronous FIFO's read port (re/empty/dout,
// with one cycle of RAM read latency) into a registered valid/ready stream.
// A 2-entry output buffer (slot0/slot1) and a one-bit in-flight tracker
// (rd_pend) let the block sustain one word per cycle. Reads are issued only
// when the returning word is guaranteed a free slot.
// Optional feature: define LDL_FIFO_RD_STREAM_CNT_EN to add the 32-bit
// xfer_cnt output. It counts accepted output words, is cleared only by rst,
// and wraps.
module ldl_fifo_rd_stream #(
    parameter int DW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   fifo_empty,
    output logic                   fifo_re,
    input  logic [DW-1:0]          fifo_dout,
    ldl_fifo_rd_stream_if.master   m,
    output logic [1:0]             occ
`ifdef LDL_FIFO_RD_STREAM_CNT_EN
    ,
    output logic [31:0]            xfer_cnt
`endif
);

    logic [1:0]    occ_q;
    logic          valid_q;
    logic          rd_pend;
    logic [DW-1:0] slot0;
    logic [DW-1:0] slot1;
    logic          pop;
    logic [2:0]    occ_sum;

    // valid_q always equals (occ_q != 0). It is kept as its own flop so that
    // m_valid comes straight from a register.
    assign pop     = valid_q & m.m_ready;

    // Occupancy once this cycle's returning word and this cycle's pop are
    // accounted for. The sum is held in 3 bits so the issue compare cannot wrap.
    assign occ_sum = {1'b0, occ_q} + {2'b00, rd_pend} - {2'b00, pop};

    // Issue a read only if its data, arriving next cycle, will have a free slot.
    assign fifo_re = !rst && !fifo_empty && !flush && (occ_sum <= 3'd1);

    assign occ       = occ_q;
    assign m.m_valid = valid_q;
    assign m.m_data  = slot0;

    // Occupancy, valid flag and in-flight tracker. Flush empties the buffer.
    // Because fifo_re is held low during flush, no read is left in flight
    // afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q   <= 2'd0;
            valid_q <= 1'b0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= fifo_re;
            if (flush) begin
                occ_q   <= 2'd0;
                valid_q <= 1'b0;
            end else begin
                occ_q   <= occ_sum[1:0];
                valid_q <= (occ_sum != 3'd0);
            end
        end
    end

    // Buffer slots: slot0 is the head presented on m_data. Returning data goes
    // into the first slot that is free after any pop, which preserves FIFO
    // order. Data returning during a flush is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
        end else if (!flush) begin
            if (rd_pend) begin
                case (occ_q)
                    2'd0: slot0 <= fifo_dout;
                    2'd1: begin
                        if (pop) begin
                            slot0 <= fifo_dout;
                        end else begin
                            slot1 <= fifo_dout;
                        end
                    end
                    default: begin
                        slot0 <= slot1;
                        slot1 <= fifo_dout;
                    end
                endcase
            end else if (pop && (occ_q == 2'd2)) begin
                slot0 <= slot1;
            end
        end
    end

    // A returning word with both slots full and no pop would be lost. The
    // issue rule is meant to make this unreachable.
    no_capture_overflow: assert property (
        @(posedge clk) disable iff (rst)
        !(rd_pend && (occ_q == 2'd2) && !pop)
    );

`ifdef LDL_FIFO_RD_STREAM_CNT_EN
    // Transfer counter: counts every pop, including one in a flush cycle.
    // It wraps at 2^32 and only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt <= 32'd0;
        end else if (pop) begin
            xfer_cnt <= xfer_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ldl_fifo_rd_stream.sv
// tb_ldl_fifo_rd_stream: directed bench for the FIFO read-side stream adapter.
// A small behavioural FIFO feeds the DUT. Each task applies a hand-worked
// cycle table of {m_valid, fifo_re, occ} and m_data. Monitors gather accepted
// words and watch the buffer bound and the hold rule. Builds with
// LDL_FIFO_RD_STREAM_CNT_EN also exercise xfer_cnt.
module tb_ldl_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       fifo_empty;
    logic       fifo_re;
    logic [7:0] fifo_dout = 8'h00;
    logic [1:0] occ;
`ifdef LDL_FIFO_RD_STREAM_CNT_EN
    logic [31:0] xfer_cnt;
`endif

    ldl_fifo_rd_stream_if #(.DW(8)) sif ();

    ldl_fifo_rd_stream #(.DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_re    (fifo_re),
        .fifo_dout  (fifo_dout),
        .m          (sif.master),
        .occ        (occ)
`ifdef LDL_FIFO_RD_STREAM_CNT_EN
        ,
        .xfer_cnt   (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural FIFO: empty when the pointers match. Read data appears on
    // fifo_dout one cycle after an accepted read.
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    // FIFO read port with one cycle of latency.
    always @(posedge clk) begin
        if (fifo_re) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    task automatic push(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    // Monitors: gather accepted words, count reads, and check two rules:
    // occ plus the in-flight read never exceeds 2, and a stalled word stays put.
    logic [7:0] rx_q [$];
    int         inv_bad   = 0;
    int         hold_bad  = 0;
    int         re_cnt    = 0;
    int         occ_after = 0;
    logic       prev_re   = 1'b0;
    logic       hold_pend = 1'b0;
    logic [7:0] hold_data = 8'h00;

    // Monitor process.
    always @(posedge clk) begin
        if (rst) begin
            prev_re   <= 1'b0;
            hold_pend <= 1'b0;
        end else begin
            if (sif.m_valid && sif.m_ready) rx_q.push_back(sif.m_data);
            if (fifo_re) re_cnt++;
            occ_after = int'(occ) + int'(prev_re) - ((sif.m_valid && sif.m_ready) ? 1 : 0)
                        + (fifo_re ? 1 : 0);
            if ((int'(occ) + int'(prev_re) > 2) || (occ_after > 2)) inv_bad++;
            if (hold_pend && (!sif.m_valid || (sif.m_data !== hold_data))) hold_bad++;
            prev_re   <= fifo_re;
            hold_pend <= sif.m_valid && !sif.m_ready && !flush;
            hold_data <= sif.m_data;
        end
    end

    task automatic test_reset;
        push(8'hAA);
        @(posedge clk); #1;
        total++;
        if ({sif.m_valid, fifo_re, occ} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_ctrl got=%b exp=0000", {sif.m_valid, fifo_re, occ});
        end
        total++;
        if (sif.m_data !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_data got=%h exp=00", sif.m_data);
        end
`ifdef LDL_FIFO_RD_STREAM_CNT_EN
        total++;
        if (xfer_cnt !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_cnt got=%0d exp=0", xfer_cnt);
        end
`endif
        wr_ptr = rd_ptr;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1; #1;
        total++;
        if ({sif.m_valid, fifo_re, occ} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_idle got=%b exp=0000", {sif.m_valid, fifo_re, occ});
        end
    endtask

    task automatic test_stream;
        logic [3:0] exp_vro [8];
        logic [7:0] exp_d   [8];
        exp_vro = '{4'b0100, 4'b0100, 4'b1101, 4'b1101, 4'b1101, 4'b1001, 4'b1001, 4'b0000};
        exp_d   = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00};
        rx_q.delete();
        @(posedge clk); #1;
        sif.m_ready = 1'b1;
        for (int i = 1; i <= 5; i++) push(8'(i));
        for (int c = 0; c < 8; c++) begin
            if (c != 0) begin @(posedge clk); #1; end
            #1;
            total++;
            if ({sif.m_valid, fifo_re, occ} !== exp_vro[c]) begin
                bad++;
                $display("[TB] FAIL stream_ctrl cycle=%0d got=%b exp=%b", c, {sif.m_valid, fifo_re, occ}, exp_vro[c]);
            end
            if (exp_vro[c][3]) begin
                total++;
                if (sif.m_data !== exp_d[c]) begin
                    bad++;
                    $display("[TB] FAIL stream_data cycle=%0d got=%h exp=%h", c, sif.m_data, exp_d[c]);
                end
            end
        end
        total++;
        if (rx_q.size() != 5) begin
            bad++;
            $display("[TB] FAIL stream_count got=%0d exp=5", rx_q.size());
        end
    endtask

    task automatic test_backpressure;
        logic [3:0] exp_vro [11];
        logic [7:0] exp_d   [11];
        exp_vro = '{4'b0100, 4'b0100, 4'b1001, 4'b1010, 4'b1010, 4'b1010,
                    4'b1110, 4'b1101, 4'b1001, 4'b1001, 4'b0000};
        exp_d   = '{8'h00, 8'h00, 8'h21, 8'h21, 8'h21, 8'h21,
                    8'h21, 8'h22, 8'h23, 8'h24, 8'h00};
        rx_q.delete();
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            sif.m_ready = (c >= 6);
            if (c == 0) for (int i = 1; i <= 4; i++) push(8'h20 + 8'(i));
            #1;
            total++;
            if ({sif.m_valid, fifo_re, occ} !== exp_vro[c]) begin
                bad++;
                $display("[TB] FAIL bp_ctrl cycle=%0d got=%b exp=%b", c, {sif.m_valid, fifo_re, occ}, exp_vro[c]);
            end
            if (exp_vro[c][3]) begin
                total++;
                if (sif.m_data !== exp_d[c]) begin
                    bad++;
                    $display("[TB] FAIL bp_data cycle=%0d got=%h exp=%h", c, sif.m_data, exp_d[c]);
                end
            end
        end
        total++;
        if (rx_q.size() != 4) begin
            bad++;
            $display("[TB] FAIL bp_count got=%0d exp=4", rx_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (rx_q[i] !== 8'h21 + 8'(i)) begin
                    bad++;
                    $display("[TB] FAIL bp_order idx=%0d got=%h exp=%h", i, rx_q[i], 8'h21 + 8'(i));
                end
            end
        end
    endtask

    task automatic test_toggle;
        int inv0, hold0, re0, cyc;
        inv0  = inv_bad;
        hold0 = hold_bad;
        re0   = re_cnt;
        cyc   = 0;
        rx_q.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        sif.m_ready = 1'b1;
        while ((rx_q.size() < 16) && (cyc < 120)) begin
            @(posedge clk); #1;
            sif.m_ready = ~sif.m_ready;
            cyc++;
        end
        sif.m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (rx_q.size() != 16) begin
            bad++;
            $display("[TB] FAIL toggle_count got=%0d exp=16", rx_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                total++;
                if (rx_q[i] !== 8'h10 + 8'(i)) begin
                    bad++;
                    $display("[TB] FAIL toggle_order idx=%0d got=%h exp=%h", i, rx_q[i], 8'h10 + 8'(i));
                end
            end
        end
        total++;
        if (inv_bad - inv0 != 0) begin
            bad++;
            $display("[TB] FAIL toggle_bound got=%0d violations exp=0", inv_bad - inv0);
        end
        total++;
        if (hold_bad - hold0 != 0) begin
            bad++;
            $display("[TB] FAIL toggle_hold got=%0d violations exp=0", hold_bad - hold0);
        end
        total++;
        if (re_cnt - re0 != 16) begin
            bad++;
            $display("[TB] FAIL toggle_reads got=%0d exp=16", re_cnt - re0);
        end
    endtask

    task automatic test_drain_resume;
        logic [3:0] exp_vro [11];
        logic [7:0] exp_d   [11];
        exp_vro = '{4'b0100, 4'b0100, 4'b1101, 4'b1001, 4'b1001, 4'b0000,
                    4'b0000, 4'b0100, 4'b0000, 4'b1001, 4'b0000};
        exp_d   = '{8'h00, 8'h00, 8'h31, 8'h32, 8'h33, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h34, 8'h00};
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            sif.m_ready = 1'b1;
            if (c == 0) for (int i = 1; i <= 3; i++) push(8'h30 + 8'(i));
            if (c == 7) push(8'h34);
            #1;
            total++;
            if ({sif.m_valid, fifo_re, occ} !== exp_vro[c]) begin
                bad++;
                $display("[TB] FAIL drain_ctrl cycle=%0d got=%b exp=%b", c, {sif.m_valid, fifo_re, occ}, exp_vro[c]);
            end
            if (exp_vro[c][3]) begin
                total++;
                if (sif.m_data !== exp_d[c]) begin
                    bad++;
                    $display("[TB] FAIL drain_data cycle=%0d got=%h exp=%h", c, sif.m_data, exp_d[c]);
                end
            end
        end
    endtask

    task automatic test_flush;
        logic [3:0] exp_vro [9];
        logic [7:0] exp_d   [9];
        exp_vro = '{4'b0100, 4'b0100, 4'b1001, 4'b0100, 4'b0100,
                    4'b1001, 4'b1010, 4'b1001, 4'b0000};
        exp_d   = '{8'h00, 8'h00, 8'h41, 8'h00, 8'h00,
                    8'h43, 8'h43, 8'h44, 8'h00};
        rx_q.delete();
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            sif.m_ready = (c >= 6);
            flush       = (c == 2);
            if (c == 0) for (int i = 1; i <= 4; i++) push(8'h40 + 8'(i));
            #1;
            total++;
            if ({sif.m_valid, fifo_re, occ} !== exp_vro[c]) begin
                bad++;
                $display("[TB] FAIL flush_ctrl cycle=%0d got=%b exp=%b", c, {sif.m_valid, fifo_re, occ}, exp_vro[c]);
            end
            if (exp_vro[c][3]) begin
                total++;
                if (sif.m_data !== exp_d[c]) begin
                    bad++;
                    $display("[TB] FAIL flush_data cycle=%0d got=%h exp=%h", c, sif.m_data, exp_d[c]);
                end
            end
        end
        flush = 1'b0;
        total++;
        if ((rx_q.size() != 2) || (rx_q[0] !== 8'h43) || (rx_q[1] !== 8'h44)) begin
            bad++;
            $display("[TB] FAIL flush_order got=%0d words first=%h exp=2 words 43,44", rx_q.size(),
                     (rx_q.size() > 0) ? rx_q[0] : 8'h00);
        end
    endtask

    task automatic test_flush_pop;
        logic [3:0] exp_vro [5];
        exp_vro = '{4'b0100, 4'b0100, 4'b1001, 4'b0000, 4'b0000};
        rx_q.delete();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            sif.m_ready = 1'b1;
            flush       = (c == 2);
            if (c == 0) begin
                push(8'h51);
                push(8'h52);
            end
            #1;
            total++;
            if ({sif.m_valid, fifo_re, occ} !== exp_vro[c]) begin
                bad++;
                $display("[TB] FAIL flushpop_ctrl cycle=%0d got=%b exp=%b", c, {sif.m_valid, fifo_re, occ}, exp_vro[c]);
            end
        end
        flush = 1'b0;
        total++;
        if ((rx_q.size() != 1) || (rx_q[0] !== 8'h51)) begin
            bad++;
            $display("[TB] FAIL flushpop_xfer got=%0d words first=%h exp=1 word 51", rx_q.size(),
                     (rx_q.size() > 0) ? rx_q[0] : 8'h00);
        end
    endtask

`ifdef LDL_FIFO_RD_STREAM_CNT_EN
    task automatic test_cnt;
        int order_bad;
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        rx_q.delete();
        sif.m_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            push(8'(i));
        end
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (xfer_cnt !== 32'd300) begin
            bad++;
            $display("[TB] FAIL cnt_300 got=%0d exp=300", xfer_cnt);
        end
        order_bad = 0;
        if (rx_q.size() == 300) begin
            for (int i = 0; i < 300; i++) if (rx_q[i] !== 8'(i)) order_bad++;
        end else begin
            order_bad = 1;
        end
        total++;
        if (order_bad != 0) begin
            bad++;
            $display("[TB] FAIL cnt_order got=%0d words %0d wrong exp=300 words 0 wrong", rx_q.size(), order_bad);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) push(8'hC0 + 8'(i));
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({sif.m_valid, fifo_re, occ} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL cnt_rst_ctrl got=%b exp=0000", {sif.m_valid, fifo_re, occ});
        end
        total++;
        if ((sif.m_data !== 8'h00) || (xfer_cnt !== 32'd0)) begin
            bad++;
            $display("[TB] FAIL cnt_rst_zero got=data %h cnt %0d exp=data 00 cnt 0", sif.m_data, xfer_cnt);
        end
        @(posedge clk); #1;
        wr_ptr = rd_ptr;
        rst    = 1'b0;
        rx_q.delete();
        for (int i = 0; i < 7; i++) push(8'hD0 + 8'(i));
        repeat (12) @(posedge clk);
        #1;
        total++;
        if (xfer_cnt !== 32'd7) begin
            bad++;
            $display("[TB] FAIL cnt_after_rst got=%0d exp=7", xfer_cnt);
        end
        total++;
        if ((rx_q.size() != 7) || (rx_q[0] !== 8'hD0) || (rx_q[6] !== 8'hD6)) begin
            bad++;
            $display("[TB] FAIL cnt_rst_words got=%0d words exp=7 words D0..D6", rx_q.size());
        end
    endtask
`endif

    // Test sequence.
    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        sif.m_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_drain_resume();
        test_flush();
        test_flush_pop();
`ifdef LDL_FIFO_RD_STREAM_CNT_EN
        test_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
